l2_port_arbiter: RTL and testbench
==================================

# l2_port_arbiter

Parametrised N-channel front end for the shared L2 cache: arbitrates line requests from any number of L1 requesters (icache, dcache, extra thread or core ports) onto the single L2 request port. It replaces fixed two-way icache/dcache wiring with round-robin arbitration and per-channel completion. The read line is returned to the owning channel only. It sits between the L1 top blocks and the L2 top, in the L2 clock domain.

## Interface
- N_CH, 2, number of requesting channels (≥1, any integer)
- ADDR_W, 32, request address width
- LINE_W, 128, line width between L1 and L2
- CNT_W, 16, perf counter width (used only with ARB_PERF_CNT_EN)

- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- ch_req  in  N_CH  per-channel request; held until ch_gnt
- ch_rw  in  N_CH  1 = write-back, 0 = line read
- ch_addr  in  N_CH*ADDR_W  channel i in bits [i*ADDR_W +: ADDR_W]
- ch_wd  in  N_CH*LINE_W  write-back line, same packing
- ch_gnt  out  N_CH  one-hot, one-cycle pulse: request captured
- ch_complete  out  N_CH  one-hot, one-cycle pulse: transaction finished
- ch_rd  out  LINE_W  returned line; valid only with ch_complete
- ch_busy  out  N_CH  ch_req[i] & ~ch_complete[i]
- cur_ch  out  $clog2(N_CH) (min 1)  current owner index
- l2_req  out  1  request to L2
- l2_rw, l2_addr, l2_wd  out  1/ADDR_W/LINE_W  captured request
- l2_rdy  in  1  L2 accepts when l2_req & l2_rdy
- l2_complete  in  1  L2 finished; l2_rd valid this cycle
- l2_rd  in  LINE_W  L2 read line
- perf_gnt_cnt, perf_wait_cnt  out  N_CH*CNT_W  (ARB_PERF_CNT_EN only)

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: if any ch_req, winner = first requesting channel at or after rr_ptr (wrapping N_CH-1 → 0). Capture owner, rw, addr, wd. Pulse ch_gnt[owner]. → REQ.
- REQ: l2_req=1. On l2_rdy → WAIT.
- WAIT: on l2_complete, capture l2_rd into line register. → DONE.
- DONE: ch_complete[owner]=1, ch_rd=line register, rr_ptr ← owner+1 (wrap). → IDLE.
- A write-back completes the same way; ch_rd content is don't-care for writes.
- l2_complete outside WAIT is ignored (protocol violation). l2_rdy outside REQ is ignored.
- A channel dropping ch_req before its grant is withdrawn; no side effect.
- A channel holding ch_req after ch_complete re-arbitrates on the next IDLE. Because rr_ptr has advanced, any other requester wins first.
- N_CH=1: rr_ptr is constant 0; otherwise behaviour is identical.

## Timing
- ch_gnt, ch_complete, ch_rd, l2_* are registered outputs.
- ch_req sampled in IDLE at edge k: ch_gnt and l2_req high in cycle k+1.
- l2_rdy high in cycle k+1: WAIT from k+2. Earliest l2_complete is in k+2, giving ch_complete in k+3.
- Minimum request-to-complete latency is 3 cycles. Back-to-back issue: next grant is visible 1 cycle after DONE (IDLE is one cycle).
- Captured address/data are stable on l2_* from REQ through WAIT.
- Reset (rst=0 at an edge) from any state:
  - state=IDLE, rr_ptr=0, cur_ch=0.
  - All outputs 0; line register 0; counters 0.
  - An in-flight L2 transaction is abandoned; L2 is reset in the same cycle.

## Configuration
- ARB_PERF_CNT_EN defined:
  - perf_gnt_cnt[i] increments on each ch_gnt[i].
  - perf_wait_cnt[i] increments every cycle ch_busy[i] is high.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: counter ports and logic are absent.

## Structure
- Shared header l2_cache.h holds the FSM state encodings and the RW read/write constants.
- One sub-module, arb_rr_pick: combinational round-robin picker. Inputs: req vector and pointer. Outputs: valid and winner index.

## Test plan
- N_CH=2, ch_req=2'b01, addr 0x0000_1040, read; l2_rdy=1; l2_complete in WAIT with l2_rd=0xA5…A5 → ch_gnt=01 at k+1, ch_complete=01 at k+3, ch_rd=0xA5…A5.
- Both channels requesting continuously, rr_ptr=0 → grants alternate 0,1,0,1; no channel gets two grants in a row.
- N_CH=3 with channel 2 owner, then all channels request → next winner is 0 (wrap).
- l2_rdy held 0 for 5 cycles in REQ → l2_req stays high, l2_addr stable, no ch_complete. Spurious l2_complete in REQ → ignored.
- rst=0 asserted during WAIT → next cycle state IDLE, all outputs 0. A later request from channel 1 is granted first, since rr_ptr=0 and channel 0 is idle.
- With ARB_PERF_CNT_EN, CNT_W=4: 20 grants to channel 0 → perf_gnt_cnt[0]=15 (saturated).

Source files
------------

// File: rtl/l2_port_arbiter_pkg.sv
// Shared definitions for the L2 port arbiter: FSM state encodings, read/write
// constants and the index-width helper.
package l2_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } arb_state_e;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Width of a channel index; a single channel still gets one bit.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l2_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping
// from N-1 back to 0.
module arb_rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          vld,
    output logic [IW-1:0] idx
);

    int cand;

    // Scan from the farthest candidate down so the nearest one to ptr wins.
    always_comb begin
        vld  = 1'b0;
        idx  = '0;
        cand = 0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % N;
            if (req[cand]) begin
                vld = 1'b1;
                idx = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// N-channel round-robin front end onto the single L2 request port.
// Optional per-channel grant/wait counters are enabled with ARB_PERF_CNT_EN.
module l2_port_arbiter
    import l2_port_arbiter_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128,
    parameter int CNT_W  = 16,
    localparam int CH_W  = ch_idx_w(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          ch_req,
    input  logic [N_CH-1:0]          ch_rw,
    input  logic [N_CH*ADDR_W-1:0]   ch_addr,
    input  logic [N_CH*LINE_W-1:0]   ch_wd,
    output logic [N_CH-1:0]          ch_gnt,
    output logic [N_CH-1:0]          ch_complete,
    output logic [LINE_W-1:0]        ch_rd,
    output logic [N_CH-1:0]          ch_busy,
    output logic [CH_W-1:0]          cur_ch,
    output logic                     l2_req,
    output logic                     l2_rw,
    output logic [ADDR_W-1:0]        l2_addr,
    output logic [LINE_W-1:0]        l2_wd,
    input  logic                     l2_rdy,
    input  logic                     l2_complete,
    input  logic [LINE_W-1:0]        l2_rd
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [N_CH*CNT_W-1:0]    perf_gnt_cnt,
    output logic [N_CH*CNT_W-1:0]    perf_wait_cnt
`endif
);

    arb_state_e        state_q, state_d;
    logic [CH_W-1:0]   owner_q, owner_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wd_q, wd_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [N_CH-1:0]   gnt_q, gnt_d;
    logic [N_CH-1:0]   cmpl_q, cmpl_d;
    logic              l2_req_q, l2_req_d;

    logic              pick_vld;
    logic [CH_W-1:0]   pick_idx;

    arb_rr_pick #(.N(N_CH), .IW(CH_W)) u_pick (
        .req (ch_req),
        .ptr (rr_ptr_q),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wd_d     = wd_q;
        line_d   = line_q;
        gnt_d    = '0;
        cmpl_d   = '0;
        l2_req_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    owner_d         = pick_idx;
                    rw_d            = ch_rw[pick_idx];
                    addr_d          = ch_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    wd_d            = ch_wd[int'(pick_idx)*LINE_W +: LINE_W];
                    gnt_d[pick_idx] = 1'b1;
                    l2_req_d        = 1'b1;
                    state_d         = ST_REQ;
                end
            end
            ST_REQ: begin
                if (l2_rdy) state_d = ST_WAIT;
                else        l2_req_d = 1'b1;
            end
            ST_WAIT: begin
                if (l2_complete) begin
                    line_d          = l2_rd;
                    cmpl_d[owner_q] = 1'b1;
                    state_d         = ST_DONE;
                end
            end
            ST_DONE: begin
                // Pointer moves past the owner so a persistent requester yields.
                rr_ptr_d = (int'(owner_q) >= N_CH - 1) ? '0 : owner_q + CH_W'(1);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            rw_q     <= RW_READ;
            addr_q   <= '0;
            wd_q     <= '0;
            line_q   <= '0;
            gnt_q    <= '0;
            cmpl_q   <= '0;
            l2_req_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
            line_q   <= line_d;
            gnt_q    <= gnt_d;
            cmpl_q   <= cmpl_d;
            l2_req_q <= l2_req_d;
        end
    end

    assign ch_gnt      = gnt_q;
    assign ch_complete = cmpl_q;
    assign ch_rd       = line_q;
    assign ch_busy     = ch_req & ~cmpl_q;
    assign cur_ch      = owner_q;
    assign l2_req      = l2_req_q;
    assign l2_rw       = rw_q;
    assign l2_addr     = addr_q;
    assign l2_wd       = wd_q;

`ifdef ARB_PERF_CNT_EN
    logic [N_CH-1:0][CNT_W-1:0] gnt_cnt_q, gnt_cnt_d;
    logic [N_CH-1:0][CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Saturating counters: they stick at all-ones until reset.
    always_comb begin
        gnt_cnt_d  = gnt_cnt_q;
        wait_cnt_d = wait_cnt_q;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt_q[i] && (gnt_cnt_q[i] != '1))
                gnt_cnt_d[i] = gnt_cnt_q[i] + CNT_W'(1);
            if (ch_busy[i] && (wait_cnt_q[i] != '1))
                wait_cnt_d[i] = wait_cnt_q[i] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            gnt_cnt_q  <= gnt_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign perf_gnt_cnt  = gnt_cnt_q;
    assign perf_wait_cnt = wait_cnt_q;
`else
    if (CNT_W < 1) begin : g_bad_cnt_w
    end
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench: cycle table for a 2-channel arbiter plus hand sequences for
// reset, 3-channel wrap and (when enabled) counter saturation.
module tb_l2_port_arbiter;
    import l2_port_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int n_chk  = 0;
    int n_fail = 0;

    // 2-channel instance
    logic [1:0]   req2, rw2, gnt2, cmpl2, busy2;
    logic [63:0]  addr2;
    logic [255:0] wd2;
    logic [127:0] rd2, l2wd2, l2rd2;
    logic [0:0]   cur2;
    logic         l2req2, l2rw2, rdy2, l2c2;
    logic [31:0]  l2addr2;
`ifdef ARB_PERF_CNT_EN
    logic [7:0]   pg2, pw2;
`endif

    l2_port_arbiter #(.N_CH(2), .ADDR_W(32), .LINE_W(128), .CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .ch_req(req2), .ch_rw(rw2), .ch_addr(addr2), .ch_wd(wd2),
        .ch_gnt(gnt2), .ch_complete(cmpl2), .ch_rd(rd2), .ch_busy(busy2), .cur_ch(cur2),
        .l2_req(l2req2), .l2_rw(l2rw2), .l2_addr(l2addr2), .l2_wd(l2wd2),
        .l2_rdy(rdy2), .l2_complete(l2c2), .l2_rd(l2rd2)
`ifdef ARB_PERF_CNT_EN
        , .perf_gnt_cnt(pg2), .perf_wait_cnt(pw2)
`endif
    );

    // 3-channel instance
    logic [2:0]  req3, rw3, gnt3, cmpl3, busy3;
    logic [47:0] addr3;
    logic [23:0] wd3;
    logic [7:0]  rd3, l2wd3, l2rd3;
    logic [1:0]  cur3;
    logic        l2req3, l2rw3, rdy3, l2c3;
    logic [15:0] l2addr3;
`ifdef ARB_PERF_CNT_EN
    logic [47:0] pg3, pw3;
`endif

    l2_port_arbiter #(.N_CH(3), .ADDR_W(16), .LINE_W(8)) u3 (
        .clk(clk), .rst(rst), .ch_req(req3), .ch_rw(rw3), .ch_addr(addr3), .ch_wd(wd3),
        .ch_gnt(gnt3), .ch_complete(cmpl3), .ch_rd(rd3), .ch_busy(busy3), .cur_ch(cur3),
        .l2_req(l2req3), .l2_rw(l2rw3), .l2_addr(l2addr3), .l2_wd(l2wd3),
        .l2_rdy(rdy3), .l2_complete(l2c3), .l2_rd(l2rd3)
`ifdef ARB_PERF_CNT_EN
        , .perf_gnt_cnt(pg3), .perf_wait_cnt(pw3)
`endif
    );

    localparam logic [31:0]  A0 = 32'h0000_1040;
    localparam logic [31:0]  A1 = 32'h0000_2080;
    localparam logic [127:0] W0 = {16{8'h11}};
    localparam logic [127:0] W1 = {16{8'h22}};

    typedef struct {
        logic [1:0]  req;
        logic        rdy;
        logic        l2c;
        logic [7:0]  rdb;
        logic [1:0]  gnt;
        logic [1:0]  cmpl;
        logic [1:0]  busy;
        logic        l2req;
        logic        cur;
        logic [31:0] addr;
    } vec_t;

    localparam int NV = 27;
    vec_t tv[NV];

    function automatic vec_t mk(input logic [1:0] req, input logic rdy, input logic l2c,
                                input logic [7:0] rdb, input logic [1:0] gnt,
                                input logic [1:0] cmpl, input logic [1:0] busy,
                                input logic l2req, input logic cur, input logic [31:0] addr);
        vec_t v;
        v.req = req; v.rdy = rdy; v.l2c = l2c; v.rdb = rdb; v.gnt = gnt;
        v.cmpl = cmpl; v.busy = busy; v.l2req = l2req; v.cur = cur; v.addr = addr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One full 3-channel transaction: grant, accept, complete, back to idle.
    task automatic txn3(input logic [2:0] req, input logic [2:0] exp_gnt, input logic [15:0] exp_addr,
                        input logic [7:0] line);
        req3 = req;
        step();
        chk("n3 gnt", gnt3, exp_gnt);
        chk("n3 l2_addr", l2addr3, exp_addr);
        req3 = '0; rdy3 = 1'b1;
        step();
        rdy3 = 1'b0; l2c3 = 1'b1; l2rd3 = line;
        step();
        chk("n3 complete", cmpl3, exp_gnt);
        chk("n3 ch_rd", rd3, line);
        l2c3 = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b0;
        req2 = '0; rw2 = {RW_WRITE, RW_READ}; addr2 = {A1, A0}; wd2 = {W1, W0};
        rdy2 = 1'b0; l2c2 = 1'b0; l2rd2 = '0;
        req3 = '0; rw3 = '0; addr3 = {16'h0300, 16'h0200, 16'h0100}; wd3 = 24'h332211;
        rdy3 = 1'b0; l2c3 = 1'b0; l2rd3 = '0;

        //           req   rdy  l2c  rdb    gnt    cmpl   busy   l2r  cur addr
        tv[0]  = mk(2'b01, 1'b0, 1'b0, 8'h00, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, A0);
        tv[1]  = mk(2'b00, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, A0);
        tv[2]  = mk(2'b00, 1'b0, 1'b1, 8'hA5, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, A0);
        tv[3]  = mk(2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, A0);
        tv[4]  = mk(2'b11, 1'b0, 1'b0, 8'h00, 2'b10, 2'b00, 2'b11, 1'b1, 1'b1, A1);
        tv[5]  = mk(2'b11, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b1, A1);
        tv[6]  = mk(2'b11, 1'b0, 1'b1, 8'h3C, 2'b00, 2'b10, 2'b01, 1'b0, 1'b1, A1);
        tv[7]  = mk(2'b11, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b1, A1);
        tv[8]  = mk(2'b11, 1'b0, 1'b0, 8'h00, 2'b01, 2'b00, 2'b11, 1'b1, 1'b0, A0);
        tv[9]  = mk(2'b11, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, A0);
        tv[10] = mk(2'b11, 1'b0, 1'b1, 8'h5A, 2'b00, 2'b01, 2'b10, 1'b0, 1'b0, A0);
        tv[11] = mk(2'b11, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, A0);
        tv[12] = mk(2'b11, 1'b0, 1'b0, 8'h00, 2'b10, 2'b00, 2'b11, 1'b1, 1'b1, A1);
        tv[13] = mk(2'b11, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b1, A1);
        tv[14] = mk(2'b01, 1'b0, 1'b1, 8'hC3, 2'b00, 2'b10, 2'b01, 1'b0, 1'b1, A1);
        tv[15] = mk(2'b01, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1, A1);
        tv[16] = mk(2'b01, 1'b0, 1'b0, 8'h00, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, A0);
        tv[17] = mk(2'b10, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, A0);
        tv[18] = mk(2'b10, 1'b0, 1'b1, 8'hFF, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, A0);
        tv[19] = mk(2'b10, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, A0);
        tv[20] = mk(2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, A0);
        tv[21] = mk(2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, A0);
        tv[22] = mk(2'b00, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, A0);
        tv[23] = mk(2'b00, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, A0);
        tv[24] = mk(2'b00, 1'b0, 1'b1, 8'h96, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, A0);
        tv[25] = mk(2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, A0);
        tv[26] = mk(2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, A0);

        step();
        step();
        chk("reset gnt", gnt2, 2'b00);
        chk("reset complete", cmpl2, 2'b00);
        chk("reset l2_req", l2req2, 1'b0);
        chk("reset cur_ch", cur2, 1'b0);
        chk("reset l2_addr", l2addr2, 32'h0);
        chk("reset ch_rd", rd2, 128'h0);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            req2 = tv[i].req; rdy2 = tv[i].rdy; l2c2 = tv[i].l2c; l2rd2 = {16{tv[i].rdb}};
            step();
            chk($sformatf("v%0d gnt", i), gnt2, tv[i].gnt);
            chk($sformatf("v%0d complete", i), cmpl2, tv[i].cmpl);
            chk($sformatf("v%0d busy", i), busy2, tv[i].busy);
            chk($sformatf("v%0d l2_req", i), l2req2, tv[i].l2req);
            chk($sformatf("v%0d cur_ch", i), cur2, tv[i].cur);
            chk($sformatf("v%0d l2_addr", i), l2addr2, tv[i].addr);
            chk($sformatf("v%0d l2_rw", i), l2rw2, (tv[i].addr == A1) ? RW_WRITE : RW_READ);
            chk($sformatf("v%0d l2_wd", i), l2wd2, (tv[i].addr == A1) ? W1 : W0);
            if (tv[i].cmpl != 2'b00)
                chk($sformatf("v%0d ch_rd", i), rd2, {16{tv[i].rdb}});
        end
        l2c2 = 1'b0; rdy2 = 1'b0;

        // Reset in WAIT with channel 1 owning and rr_ptr at 1.
        req2 = 2'b10;
        step();
        chk("rst-seq gnt", gnt2, 2'b10);
        req2 = 2'b00; rdy2 = 1'b1;
        step();
        rdy2 = 1'b0; rst = 1'b0;
        step();
        chk("rst-wait gnt", gnt2, 2'b00);
        chk("rst-wait complete", cmpl2, 2'b00);
        chk("rst-wait l2_req", l2req2, 1'b0);
        chk("rst-wait cur_ch", cur2, 1'b0);
        chk("rst-wait l2_addr", l2addr2, 32'h0);
        chk("rst-wait l2_rw", l2rw2, 1'b0);
        chk("rst-wait l2_wd", l2wd2, 128'h0);
        chk("rst-wait ch_rd", rd2, 128'h0);
        rst = 1'b1; l2c2 = 1'b1; l2rd2 = {16{8'hEE}};
        step();
        chk("post-rst stray complete", cmpl2, 2'b00);
        l2c2 = 1'b0; req2 = 2'b11;
        step();
        chk("post-rst both gnt", gnt2, 2'b01);
        req2 = 2'b00; rdy2 = 1'b1;
        step();
        rdy2 = 1'b0; l2c2 = 1'b1; l2rd2 = {16{8'h77}};
        step();
        chk("post-rst complete", cmpl2, 2'b01);
        chk("post-rst ch_rd", rd2, {16{8'h77}});
        l2c2 = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1; req2 = 2'b10;
        step();
        chk("post-rst ch1 gnt", gnt2, 2'b10);
        chk("post-rst ch1 cur_ch", cur2, 1'b1);
        req2 = 2'b00; rdy2 = 1'b1;
        step();
        rdy2 = 1'b0; l2c2 = 1'b1;
        step();
        l2c2 = 1'b0;
        step();

        // 3-channel wrap: channel 2 owner, then all request -> 0, 1, 2, 0.
        txn3(3'b100, 3'b100, 16'h0300, 8'h12);
        txn3(3'b111, 3'b001, 16'h0100, 8'h34);
        txn3(3'b111, 3'b010, 16'h0200, 8'h56);
        txn3(3'b101, 3'b100, 16'h0300, 8'h78);
        txn3(3'b111, 3'b001, 16'h0100, 8'h9A);

`ifdef ARB_PERF_CNT_EN
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("perf reset gnt", pg2, 8'h00);
        for (int t = 0; t < 20; t++) begin
            req2 = 2'b01;
            step();
            req2 = 2'b00; rdy2 = 1'b1;
            step();
            rdy2 = 1'b0; l2c2 = 1'b1;
            step();
            l2c2 = 1'b0;
            step();
        end
        chk("perf gnt ch0 sat", pg2[3:0], 4'hF);
        chk("perf gnt ch1", pg2[7:4], 4'h0);
        chk("perf wait ch0 sat", pw2[3:0], 4'hF);
        chk("perf wait ch1", pw2[7:4], 4'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
